// File: rtl/axis_seq_gen.sv
// -----------------------------------------------------------------------------
// axis_seq_gen
//   AXI4-Stream master producing fixed-length packets of a numeric sequence.
//   Each packet starts at cfg_seed; every accepted non-final beat advances the
//   value by the latched mode/step (geometric, add, subtract, constant), all
//   modulo 2^DATA_SIZE. Outputs are registered; tready only affects state.
//
// Parameters
//   DATA_SIZE : tdata width in bits (multiple of 8, >= 8)
//   LEN_W     : width of cfg_pkt_len
//   CNT_W     : width of pkt_count
//
// Ports
//   m00_axis_aclk    in   clock, rising edge
//   m00_axis_areset  in   synchronous reset, active-high
//   m00_axis_enable  in   request to start a packet (sampled in IDLE only)
//   cfg_mode         in   00 geometric, 01 add, 10 subtract, 11 constant
//   cfg_seed         in   first beat value of each packet
//   cfg_step         in   multiplier / increment
//   cfg_pkt_len      in   beats per packet (0 treated as 1)
//   ovf_clr          in   clears ovf_sticky (a simultaneous set wins)
//   m00_axis_tready  in   sink ready
//   m00_axis_tdata   out  sequence value
//   m00_axis_tstrb   out  all ones while tvalid, else 0
//   m00_axis_tvalid  out  beat valid
//   m00_axis_tlast   out  final beat of packet
//   busy             out  high while a packet is in progress
//   pkt_count        out  completed packets, wraps
//   ovf_sticky       out  an emitted value wrapped
// -----------------------------------------------------------------------------
module axis_seq_gen #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     m00_axis_aclk,
  input  logic                     m00_axis_areset,
  input  logic                     m00_axis_enable,
  input  logic [1:0]               cfg_mode,
  input  logic [DATA_SIZE-1:0]     cfg_seed,
  input  logic [DATA_SIZE-1:0]     cfg_step,
  input  logic [LEN_W-1:0]         cfg_pkt_len,
  input  logic                     ovf_clr,
  input  logic                     m00_axis_tready,
  output logic [DATA_SIZE-1:0]     m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0]   m00_axis_tstrb,
  output logic                     m00_axis_tvalid,
  output logic                     m00_axis_tlast,
  output logic                     busy,
  output logic [CNT_W-1:0]         pkt_count,
  output logic                     ovf_sticky
);

  localparam int unsigned STRB_W = DATA_SIZE / 8;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  typedef enum logic [1:0] {
    MODE_GEO   = 2'b00,
    MODE_ADD   = 2'b01,
    MODE_SUB   = 2'b10,
    MODE_CONST = 2'b11
  } mode_e;

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [DATA_SIZE-1:0]   step_q, step_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       beat_q, beat_d;
  logic [DATA_SIZE-1:0]   tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic [2*DATA_SIZE-1:0] prod;
  logic [DATA_SIZE:0]     sum;
  logic [DATA_SIZE:0]     diff;
  logic [DATA_SIZE-1:0]   next_val;
  logic                   next_ovf;
  logic [LEN_W-1:0]       eff_len;
  logic                   handshake;
  logic                   ovf_set;

  // Sequence step and its wrap detection, computed from the current beat.
  always_comb begin
    prod     = {{DATA_SIZE{1'b0}}, tdata_q} * {{DATA_SIZE{1'b0}}, step_q};
    sum      = {1'b0, tdata_q} + {1'b0, step_q};
    diff     = {1'b0, tdata_q} - {1'b0, step_q};
    next_val = tdata_q;
    next_ovf = 1'b0;
    case (mode_q)
      MODE_GEO: begin
        next_val = prod[DATA_SIZE-1:0];
        next_ovf = |prod[2*DATA_SIZE-1:DATA_SIZE];
      end
      MODE_ADD: begin
        next_val = sum[DATA_SIZE-1:0];
        next_ovf = sum[DATA_SIZE];
      end
      MODE_SUB: begin
        next_val = diff[DATA_SIZE-1:0];
        // Borrow shows up as the extension bit of the widened difference.
        next_ovf = diff[DATA_SIZE];
      end
      default: begin
        next_val = tdata_q;
        next_ovf = 1'b0;
      end
    endcase
  end

  assign eff_len   = (cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len;
  assign handshake = tvalid_q & m00_axis_tready;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    step_d   = step_q;
    len_d    = len_q;
    beat_d   = beat_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    cnt_d    = cnt_q;
    ovf_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (m00_axis_enable) begin
          state_d  = SEND;
          mode_d   = mode_e'(cfg_mode);
          step_d   = cfg_step;
          len_d    = eff_len;
          beat_d   = '0;
          tdata_d  = cfg_seed;
          tvalid_d = 1'b1;
          tlast_d  = (eff_len == LEN_ONE);
        end
      end
      SEND: begin
        if (handshake) begin
          if (tlast_q) begin
            // tdata deliberately keeps the final value after the packet.
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            cnt_d    = cnt_q + CNT_ONE;
          end else begin
            tdata_d  = next_val;
            beat_d   = beat_q + LEN_ONE;
            tlast_d  = ((beat_q + LEN_ONE) == (len_q - LEN_ONE));
            ovf_set  = next_ovf;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_GEO;
      step_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      step_q   <= step_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = {STRB_W{tvalid_q}};
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign busy            = (state_q == SEND);
  assign pkt_count       = cnt_q;
  assign ovf_sticky      = ovf_q;

endmodule

// File: tb/tb_axis_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_seq_gen
//   Drives a 32-bit and an 8-bit instance of axis_seq_gen from shared controls
//   (the 8-bit one sees the low byte of seed/step). A packet-level reference
//   model precomputes every beat of a packet when it starts and then follows
//   the handshakes; all outputs of both instances are compared every cycle.
// -----------------------------------------------------------------------------
module tb_axis_seq_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        rdy;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [31:0] step;
  logic [7:0]  plen;

  logic [31:0] d32;
  logic [3:0]  s32;
  logic        v32, l32, b32, o32;
  logic [15:0] pc32;
  logic [7:0]  d8;
  logic [0:0]  s8;
  logic        v8, l8, b8, o8;
  logic [15:0] pc8;

  axis_seq_gen #(.DATA_SIZE(32), .LEN_W(8), .CNT_W(16)) dut32 (
    .m00_axis_aclk(clk), .m00_axis_areset(rst), .m00_axis_enable(en),
    .cfg_mode(mode), .cfg_seed(seed), .cfg_step(step), .cfg_pkt_len(plen),
    .ovf_clr(clr), .m00_axis_tready(rdy),
    .m00_axis_tdata(d32), .m00_axis_tstrb(s32), .m00_axis_tvalid(v32),
    .m00_axis_tlast(l32), .busy(b32), .pkt_count(pc32), .ovf_sticky(o32)
  );

  axis_seq_gen #(.DATA_SIZE(8), .LEN_W(8), .CNT_W(16)) dut8 (
    .m00_axis_aclk(clk), .m00_axis_areset(rst), .m00_axis_enable(en),
    .cfg_mode(mode), .cfg_seed(seed[7:0]), .cfg_step(step[7:0]), .cfg_pkt_len(plen),
    .ovf_clr(clr), .m00_axis_tready(rdy),
    .m00_axis_tdata(d8), .m00_axis_tstrb(s8), .m00_axis_tvalid(v8),
    .m00_axis_tlast(l8), .busy(b8), .pkt_count(pc8), .ovf_sticky(o8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: index 0 = 32-bit instance, 1 = 8-bit instance.
  bit          m_act  [2];
  int unsigned m_idx  [2];
  int unsigned m_len  [2];
  logic [63:0] m_hold [2];
  logic [63:0] m_cnt  [2];
  bit          m_ovf  [2];
  logic [63:0] m_vals [2][256];
  bit          m_ov   [2][256];

  function automatic int unsigned width_of(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  // {overflow, value} of one sequence step under mod 2^w arithmetic.
  function automatic logic [64:0] nxt(input int unsigned w, input logic [1:0] md,
                                      input logic [63:0] x, input logic [63:0] s);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    case (md)
      2'd0: begin r = x * s; return {((r >> w) != 64'd0), r & mask}; end
      2'd1: begin r = x + s; return {((r >> w) != 64'd0), r & mask}; end
      2'd2: begin r = x - s; return {(x < s), r & mask}; end
      default: return {1'b0, x};
    endcase
  endfunction

  task automatic model_start(input int i);
    int unsigned w;
    logic [63:0] mask;
    logic [63:0] v;
    logic [64:0] r;
    w = width_of(i);
    mask = (64'd1 << w) - 64'd1;
    m_len[i] = (plen == 8'd0) ? 1 : int'(plen);
    v = 64'(seed) & mask;
    m_vals[i][0] = v;
    m_ov[i][0] = 1'b0;
    for (int unsigned k = 1; k < m_len[i]; k++) begin
      r = nxt(w, mode, v, 64'(step) & mask);
      m_vals[i][k] = r[63:0];
      m_ov[i][k] = r[64];
      v = r[63:0];
    end
    m_act[i] = 1'b1;
    m_idx[i] = 0;
  endtask

  task automatic model_update();
    bit set_ovf;
    for (int i = 0; i < 2; i++) begin
      set_ovf = 1'b0;
      if (rst) begin
        m_act[i] = 1'b0; m_idx[i] = 0; m_hold[i] = '0; m_cnt[i] = '0; m_ovf[i] = 1'b0;
      end else begin
        if (!m_act[i]) begin
          if (en) model_start(i);
        end else if (rdy) begin
          if (m_idx[i] == m_len[i] - 1) begin
            m_act[i] = 1'b0;
            m_hold[i] = m_vals[i][m_idx[i]];
            m_cnt[i] = (m_cnt[i] + 64'd1) & 64'hFFFF;
          end else begin
            m_idx[i]++;
            set_ovf = m_ov[i][m_idx[i]];
          end
        end
        if (clr) m_ovf[i] = 1'b0;
        if (set_ovf) m_ovf[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_inst(input int i, input string nm, input logic v, input logic l,
                              input logic [63:0] d, input logic [63:0] st, input logic b,
                              input logic [63:0] pc, input logic o);
    logic [63:0] ed;
    logic el;
    el = m_act[i] && (m_idx[i] == m_len[i] - 1);
    ed = m_act[i] ? m_vals[i][m_idx[i]] : m_hold[i];
    check({nm, ".tvalid"}, 64'(v), 64'(m_act[i]));
    check({nm, ".tlast"},  64'(l), 64'(el));
    check({nm, ".tdata"},  d, ed);
    check({nm, ".tstrb"},  st, m_act[i] ? ((i == 0) ? 64'hF : 64'h1) : 64'h0);
    check({nm, ".busy"},   64'(b), 64'(m_act[i]));
    check({nm, ".pkt"},    pc, m_cnt[i]);
    check({nm, ".ovf"},    64'(o), 64'(m_ovf[i]));
  endtask

  logic        last_v [2];
  logic [63:0] last_d [2];
  logic [63:0] cap32 [$];
  logic [63:0] cap8  [$];

  task automatic step_cycle();
    if (last_v[0] && rdy) cap32.push_back(last_d[0]);
    if (last_v[1] && rdy) cap8.push_back(last_d[1]);
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_inst(0, "u32", v32, l32, 64'(d32), 64'(s32), b32, 64'(pc32), o32);
    compare_inst(1, "u8",  v8,  l8,  64'(d8),  64'(s8),  b8,  64'(pc8),  o8);
    last_v[0] = v32; last_d[0] = 64'(d32);
    last_v[1] = v8;  last_d[1] = 64'(d8);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step_cycle();
  endtask

  task automatic check_cap(input string tag, input logic [63:0] got[$], input int n,
                           input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2,
                           input logic [63:0] e3, input logic [63:0] e4);
    logic [63:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    check({tag, ".beats"}, 64'(got.size()), 64'(n));
    for (int k = 0; k < n; k++)
      check($sformatf("%s.beat%0d", tag, k), (k < got.size()) ? got[k] : 64'hDEAD_BEEF_DEAD_BEEF, e[k]);
  endtask

  task automatic start_pkt(input logic [1:0] md, input logic [31:0] sd,
                           input logic [31:0] sp, input logic [7:0] ln);
    mode = md; seed = sd; step = sp; plen = ln; en = 1'b1;
    cap32.delete(); cap8.delete();
    run(1);
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; rdy = 1'b0;
    mode = 2'd0; seed = '0; step = '0; plen = '0;
    last_v[0] = 1'b0; last_v[1] = 1'b0; last_d[0] = '0; last_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_idx[i] = 0; m_len[i] = 1; m_hold[i] = '0; m_cnt[i] = '0; m_ovf[i] = 1'b0;
    end
    run(2);
    rst = 1'b0;
    run(1);
    check("reset.tvalid", 64'(v32), 64'd0);
    check("reset.tdata", 64'(d32), 64'd0);

    // Power-of-3 packet.
    rdy = 1'b1;
    start_pkt(2'd0, 32'd1, 32'd3, 8'd4);
    run(5);
    check_cap("pow3", cap32, 4, 64'd1, 64'd3, 64'd9, 64'd27, 64'd0);
    check("pow3.pkt", 64'(pc32), 64'd1);

    // Backpressure in add mode.
    start_pkt(2'd1, 32'd10, 32'd5, 8'd3);
    rdy = 1'b1; run(1);
    rdy = 1'b0; run(2);
    rdy = 1'b1; run(1);
    rdy = 1'b0; run(1);
    rdy = 1'b1; run(2);
    check_cap("bp", cap32, 3, 64'd10, 64'd15, 64'd20, 64'd0, 64'd0);

    // Geometric overflow on the 8-bit instance, then clear.
    start_pkt(2'd0, 32'd100, 32'd3, 8'd3);
    run(4);
    check_cap("ovf8", cap8, 3, 64'd100, 64'd44, 64'd132, 64'd0, 64'd0);
    check("ovf8.sticky", 64'(o8), 64'd1);
    check("ovf32.sticky", 64'(o32), 64'd0);
    clr = 1'b1; run(1); clr = 1'b0;
    check("ovf8.cleared", 64'(o8), 64'd0);

    // Subtract borrow.
    start_pkt(2'd2, 32'd2, 32'd3, 8'd2);
    run(3);
    check_cap("sub8", cap8, 2, 64'd2, 64'd255, 64'd0, 64'd0, 64'd0);
    check("sub8.sticky", 64'(o8), 64'd1);
    check("sub32.sticky", 64'(o32), 64'd1);
    clr = 1'b1; run(1); clr = 1'b0;

    // Enable dropped and config changed after the first beat.
    start_pkt(2'd1, 32'd7, 32'd2, 8'd5);
    mode = 2'd0; step = 32'd9; seed = 32'd0; plen = 8'd1;
    run(7);
    check_cap("cfgchg", cap32, 5, 64'd7, 64'd9, 64'd11, 64'd13, 64'd15);
    check("cfgchg.busy", 64'(b32), 64'd0);

    // Length 0 behaves as a single beat.
    start_pkt(2'd1, 32'd3, 32'd1, 8'd0);
    check("len0.tlast", 64'(l32), 64'd1);
    run(2);
    check_cap("len0", cap32, 1, 64'd3, 64'd0, 64'd0, 64'd0, 64'd0);

    // Constant mode.
    start_pkt(2'd3, 32'hA5, 32'd7, 8'd3);
    run(4);
    check_cap("const", cap32, 3, 64'hA5, 64'hA5, 64'hA5, 64'd0, 64'd0);

    // Reset while stalled mid-packet, then restart.
    rst = 1'b1; run(1); rst = 1'b0;
    start_pkt(2'd1, 32'd50, 32'd1, 8'd4);
    run(1);
    rdy = 1'b0; run(2);
    rst = 1'b1; run(1); rst = 1'b0;
    check("rststall.tvalid", 64'(v32), 64'd0);
    check("rststall.tlast", 64'(l32), 64'd0);
    check("rststall.busy", 64'(b32), 64'd0);
    check("rststall.pkt", 64'(pc32), 64'd0);
    rdy = 1'b1; en = 1'b1; run(1); en = 1'b0;
    check("restart.tdata", 64'(d32), 64'd50);
    run(5);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      en   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      mode = 2'($urandom_range(0, 3));
      seed = $urandom;
      step = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      plen = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 6));
      run(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
